// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Purpose  : Iterative multiply/divide unit holding the architectural HI/LO
//            registers. Executes MULTU/MULT/DIVU/DIV one bit per clock
//            (32 CALC cycles plus one FIX cycle) and services MTHI/MTLO
//            writes while idle.
// Ports    : clk, rst        - clock, asynchronous active-high reset
//            start, op       - launch request and opcode (00 MULTU, 01 MULT,
//                              10 DIVU, 11 DIV), sampled only when idle
//            src_a, src_b    - rs / rt operands, latched at start
//            hilo_we, wdata  - MTHI (bit1) / MTLO (bit0) write port
//            busy            - operation in progress (CALC or FIX)
//            done            - one-cycle pulse, HI/LO valid with it
//            div_by_zero     - qualifies done for a zero divisor
//            hi, lo          - registered HI/LO outputs
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    input  logic [1:0]        hilo_we,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic              div_by_zero,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(DATA_W - 1);

    state_t                r_state;
    state_t                w_next_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [1:0]            r_op;
    logic                  r_sign_a;
    logic                  r_sign_b;
    logic [DATA_W-1:0]     r_a_raw;
    logic [DATA_W-1:0]     r_b;
    logic [2*DATA_W-1:0]   r_acc;
    logic [DATA_W-1:0]     r_hi;
    logic [DATA_W-1:0]     r_lo;
    logic                  r_done;
    logic                  r_dbz;

    // ------------------------------------------------------------------
    // Operand conditioning at launch: signed ops work on magnitudes and
    // remember the signs. 0x80000000 negates to itself, which is exactly
    // the correct unsigned magnitude.
    // ------------------------------------------------------------------
    logic                  w_a_neg;
    logic                  w_b_neg;
    logic [DATA_W-1:0]     w_a_mag;
    logic [DATA_W-1:0]     w_b_mag;

    assign w_a_neg = op[0] & src_a[DATA_W-1];
    assign w_b_neg = op[0] & src_b[DATA_W-1];
    assign w_a_mag = w_a_neg ? -src_a : src_a;
    assign w_b_mag = w_b_neg ? -src_b : src_b;

    logic w_is_div;
    logic w_is_signed;

    assign w_is_div    = r_op[1];
    assign w_is_signed = r_op[0];

    // ------------------------------------------------------------------
    // Multiply step: the multiplier sits in the low half of the
    // accumulator and is consumed LSB first; the partial product grows
    // in the high half and everything shifts right each cycle.
    // ------------------------------------------------------------------
    logic [DATA_W:0]       w_mul_sum;
    logic [2*DATA_W-1:0]   w_mul_next;

    assign w_mul_sum  = {1'b0, r_acc[2*DATA_W-1:DATA_W]}
                      + (r_acc[0] ? {1'b0, r_b} : {(DATA_W+1){1'b0}});
    assign w_mul_next = {w_mul_sum, r_acc[DATA_W-1:1]};

    // ------------------------------------------------------------------
    // Restoring divide step on {rem, quot}: shift left one bit, try to
    // subtract the divisor from the 33-bit shifted remainder, keep the
    // difference only when it does not borrow. A zero divisor always
    // "fits", but that case is overridden at FIX anyway.
    // ------------------------------------------------------------------
    logic [DATA_W+1:0]     w_div_trial;
    logic                  w_div_fits;
    logic [2*DATA_W-1:0]   w_div_next;

    assign w_div_trial = {1'b0, r_acc[2*DATA_W-1:DATA_W-1]} - {2'b00, r_b};
    assign w_div_fits  = ~w_div_trial[DATA_W+1];
    assign w_div_next  = w_div_fits
                       ? {w_div_trial[DATA_W-1:0], r_acc[DATA_W-2:0], 1'b1}
                       : {r_acc[2*DATA_W-2:0], 1'b0};

    // ------------------------------------------------------------------
    // Sign correction applied in FIX.
    // ------------------------------------------------------------------
    logic [2*DATA_W-1:0]   w_prod;
    logic [DATA_W-1:0]     w_quot;
    logic [DATA_W-1:0]     w_rem;
    logic                  w_b_zero;

    assign w_prod   = (w_is_signed & (r_sign_a ^ r_sign_b)) ? -r_acc : r_acc;
    assign w_quot   = (w_is_signed & (r_sign_a ^ r_sign_b))
                    ? -r_acc[DATA_W-1:0] : r_acc[DATA_W-1:0];
    assign w_rem    = (w_is_signed & r_sign_a)
                    ? -r_acc[2*DATA_W-1:DATA_W] : r_acc[2*DATA_W-1:DATA_W];
    assign w_b_zero = (r_b == {DATA_W{1'b0}});

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (start) w_next_state = S_CALC;
            S_CALC: if (r_cnt == c_last_cnt) w_next_state = S_FIX;
            S_FIX:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and HI/LO registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_op     <= 2'b00;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_a_raw  <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
            r_dbz    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_dbz  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // MTHI/MTLO land even on a start edge; the result
                    // written at FIX overwrites them later.
                    if (hilo_we[1]) r_hi <= wdata;
                    if (hilo_we[0]) r_lo <= wdata;
                    if (start) begin
                        r_op     <= op;
                        r_sign_a <= w_a_neg;
                        r_sign_b <= w_b_neg;
                        r_a_raw  <= src_a;
                        r_b      <= w_b_mag;
                        r_acc    <= {{DATA_W{1'b0}}, w_a_mag};
                        r_cnt    <= '0;
                    end
                end
                S_CALC: begin
                    r_acc <= w_is_div ? w_div_next : w_mul_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                S_FIX: begin
                    r_done <= 1'b1;
                    if (w_is_div) begin
                        if (w_b_zero) begin
                            r_hi  <= r_a_raw;
                            r_lo  <= {DATA_W{1'b1}};
                            r_dbz <= 1'b1;
                        end else begin
                            r_hi <= w_rem;
                            r_lo <= w_quot;
                        end
                    end else begin
                        r_hi <= w_prod[2*DATA_W-1:DATA_W];
                        r_lo <= w_prod[DATA_W-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy        = (r_state != S_IDLE);
    assign done        = r_done;
    assign div_by_zero = r_dbz;
    assign hi          = r_hi;
    assign lo          = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_unit
// Purpose  : Self-checking bench for muldiv_unit. A behavioural model built
//            on plain 64-bit arithmetic predicts busy/done/div_by_zero/HI/LO
//            every cycle; directed vectors with hand-computed literals pin
//            both the DUT and the model; randomized operations follow.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic [1:0]  hilo_we = 2'b00;
    logic [31:0] wdata = '0;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    muldiv_unit #(.DATA_W(32), .CNT_W(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .src_a       (src_a),
        .src_b       (src_b),
        .hilo_we     (hilo_we),
        .wdata       (wdata),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // ------------------------------------------------------------------
    // Reference arithmetic: returns {div_by_zero, HI, LO}
    // ------------------------------------------------------------------
    function automatic logic [64:0] ref_calc(input logic [1:0] f_op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        case (f_op)
            2'b00: begin
                p = {32'b0, a} * {32'b0, b};
                return {1'b0, p};
            end
            2'b01: begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                q  = sa * sb;
                return {1'b0, q[63:0]};
            end
            default: begin
                if (b == 32'h0) return {1'b1, a, 32'hFFFF_FFFF};
                if (f_op == 2'b10) begin
                    sa = longint'(a);
                    sb = longint'(b);
                end else begin
                    sa = longint'($signed(a));
                    sb = longint'($signed(b));
                end
                q = sa / sb;
                r = sa % sb;
                return {1'b0, r[31:0], q[31:0]};
            end
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Behavioural model: a busy countdown of 33 edges from the start edge
    // ------------------------------------------------------------------
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic        m_done = 1'b0;
    logic        m_dbz = 1'b0;
    int          m_cnt = 0;
    logic [64:0] pend = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_hi   <= '0;
            m_lo   <= '0;
            m_done <= 1'b0;
            m_dbz  <= 1'b0;
            m_cnt  <= 0;
        end else begin
            m_done <= 1'b0;
            m_dbz  <= 1'b0;
            if (m_cnt != 0) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    m_hi   <= pend[63:32];
                    m_lo   <= pend[31:0];
                    m_done <= 1'b1;
                    m_dbz  <= pend[64];
                end
            end else begin
                if (hilo_we[1]) m_hi <= wdata;
                if (hilo_we[0]) m_lo <= wdata;
                if (start) begin
                    pend  <= ref_calc(op, src_a, src_b);
                    m_cnt <= 33;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Literal expectations armed by the stimulus
    // ------------------------------------------------------------------
    int          lit_id = 0;
    int          lit_seen = 0;
    logic        lit_on_done = 1'b0;
    logic [31:0] lit_hi = '0;
    logic [31:0] lit_lo = '0;
    logic        lit_dbz = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Compare process: every cycle, on the falling edge
    // ------------------------------------------------------------------
    int   busy_len = 0;
    logic prev_busy = 1'b0;

    always @(negedge clk) begin
        chk("busy",        32'(busy),        32'(m_cnt != 0));
        chk("done",        32'(done),        32'(m_done));
        chk("div_by_zero", 32'(div_by_zero), 32'(m_dbz));
        chk("hi",          hi,               m_hi);
        chk("lo",          lo,               m_lo);
        if (rst) begin
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_done", 32'(done), 32'd0);
            chk("rst_hi",   hi,        32'd0);
            chk("rst_lo",   lo,        32'd0);
            busy_len  <= 0;
            prev_busy <= 1'b0;
        end else begin
            if (busy) begin
                busy_len <= busy_len + 1;
                if (busy_len > 40) chk("busy_timeout", 32'(busy_len), 32'd33);
            end else begin
                if (prev_busy) chk("busy_len", 32'(busy_len), 32'd33);
                busy_len <= 0;
            end
            prev_busy <= busy;
        end
        if (lit_id != lit_seen && (!lit_on_done || m_done)) begin
            chk("lit_hi",    hi,                lit_hi);
            chk("lit_lo",    lo,                lit_lo);
            chk("lit_dbz",   32'(div_by_zero),  32'(lit_dbz));
            chk("model_hi",  m_hi,              lit_hi);
            chk("model_lo",  m_lo,              lit_lo);
            if (lit_on_done) chk("lit_done", 32'(done), 32'd1);
            lit_seen <= lit_id;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic arm_lit(input logic [31:0] h, input logic [31:0] l,
                           input logic d, input logic on_done);
        lit_hi      = h;
        lit_lo      = l;
        lit_dbz     = d;
        lit_on_done = on_done;
        lit_id      = lit_id + 1;
    endtask

    // Launch one operation and wait out its fixed 33-edge latency; ends
    // just after the done cycle's falling edge so a new start lands on E34.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [1:0] we,
                          input logic [31:0] wd, input logic inject);
        start   = 1'b1;
        op      = o;
        src_a   = a;
        src_b   = b;
        hilo_we = we;
        wdata   = wd;
        tick();
        start   = 1'b0;
        hilo_we = 2'b00;
        src_a   = $urandom();
        src_b   = $urandom();
        if (inject) begin
            repeat (5) tick();
            start   = 1'b1;
            op      = ~o;
            src_a   = $urandom();
            src_b   = $urandom();
            hilo_we = 2'b11;
            wdata   = 32'hDEAD_BEEF;
            tick();
            start   = 1'b0;
            hilo_we = 2'b00;
            repeat (27) tick();
        end else begin
            repeat (33) tick();
        end
        @(negedge clk);
        #1;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 255));
            default: return $urandom();
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Main stimulus
    // ------------------------------------------------------------------
    initial begin
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        arm_lit(32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b1);
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 32'h0, 1'b0);
        arm_lit(32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 1'b1);
        run_op(2'b01, 32'hFFFF_FFFD, 32'h0000_0005, 2'b00, 32'h0, 1'b0);
        arm_lit(32'h4000_0000, 32'h0000_0000, 1'b0, 1'b1);
        run_op(2'b01, 32'h8000_0000, 32'h8000_0000, 2'b00, 32'h0, 1'b0);
        arm_lit(32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b1);
        run_op(2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 2'b00, 32'h0, 1'b0);
        arm_lit(32'h0000_0002, 32'h0000_000E, 1'b0, 1'b1);
        run_op(2'b10, 32'd100, 32'd7, 2'b00, 32'h0, 1'b0);
        arm_lit(32'h0000_0000, 32'h8000_0000, 1'b0, 1'b1);
        run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 2'b00, 32'h0, 1'b0);
        arm_lit(32'h0000_0064, 32'hFFFF_FFFF, 1'b1, 1'b1);
        run_op(2'b10, 32'h0000_0064, 32'h0, 2'b00, 32'h0, 1'b0);
        arm_lit(32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1, 1'b1);
        run_op(2'b11, 32'hFFFF_FFF9, 32'h0, 2'b00, 32'h0, 1'b0);

        // start/hilo_we while busy must be ignored
        arm_lit(32'h0000_0000, 32'h0123_4500, 1'b0, 1'b1);
        run_op(2'b00, 32'h0001_2345, 32'h0000_0100, 2'b00, 32'h0, 1'b1);

        // MTHI then MTLO in IDLE
        hilo_we = 2'b10;
        wdata   = 32'hCAFE_F00D;
        tick();
        hilo_we = 2'b01;
        wdata   = 32'h1234_5678;
        tick();
        hilo_we = 2'b00;
        arm_lit(32'hCAFE_F00D, 32'h1234_5678, 1'b0, 1'b0);
        repeat (2) tick();

        // Asynchronous reset in the middle of CALC
        start = 1'b1;
        op    = 2'b00;
        src_a = 32'h0000_1234;
        src_b = 32'h0000_5678;
        tick();
        start = 1'b0;
        repeat (10) tick();
        #1;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        arm_lit(32'h0000_0000, 32'h0000_0064, 1'b0, 1'b1);
        run_op(2'b10, 32'd1000, 32'd10, 2'b00, 32'h0, 1'b0);

        // Randomized operations, some with MTHI/MTLO on the start edge,
        // some with busy-time interference, some back-to-back
        for (int n = 0; n < 30; n++) begin
            run_op(2'($urandom_range(0, 3)), pick(), pick(),
                   ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00,
                   $urandom(), ($urandom_range(0, 3) == 0));
            repeat ($urandom_range(0, 2)) tick();
        end

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
